seven_seg_scanner: RTL
======================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter SHOW_CYCLES, default 1024: enabled cycles per digit-on interval; legal range 1 to 65535.
REQ-002 Parameter BLANK_CYCLES, default 16: enabled cycles of all-digits-off between digits; 0 legal (BLANK skipped).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 clk_enable  input  1  global advance qualifier; when low, all state holds.
REQ-006 display_in  input  16  active-low display register value (bitwise-inverted hex word) from the memory block.
REQ-007 lzb  input  1  leading-zero blanking enable, sampled at LOAD.
REQ-008 seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-009 digit_n  output  4  active-low digit enables; bit i drives nibble i, registered.
REQ-010 frame_start  output  1  one-cycle pulse during the enabled LOAD cycle.

Function
REQ-011 States: LOAD, SHOW, BLANK; digit index d is 2 bits; phase counter is 16 bits.
REQ-012 LOAD lasts exactly one enabled cycle: shadow <= ~display_in, lzb_q <= lzb, d <= 0, counter <= 0, next state SHOW.
REQ-013 SHOW: digit_n = ~(4'b0001 << d) unless d is blanked; seg_n = hex decode of shadow[4d+3:4d]; exit after SHOW_CYCLES enabled cycles.
REQ-014 BLANK: digit_n = 4'hF, seg_n = 7'h7F; exit after BLANK_CYCLES enabled cycles; skipped when BLANK_CYCLES = 0.
REQ-015 SHOW/BLANK exit: d = 3 goes to LOAD; otherwise d <= d+1, next state SHOW.
REQ-016 Frame period = 1 + 4*(SHOW_CYCLES+BLANK_CYCLES) enabled cycles.
REQ-017 Outputs are registered: values for a state appear the cycle after the state is entered.
REQ-018 display_in changes outside LOAD SHALL NOT affect the current frame (no tearing).
REQ-019 Leading-zero blanking: with lzb_q = 1, digit d in 1..3 is blanked if nibbles d..3 are all zero; digit 0 is never blanked.
REQ-020 A blanked digit keeps SHOW timing, with digit_n = 4'hF and seg_n = 7'h7F.
REQ-021 Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
REQ-022 clk_enable low freezes state, counter, shadow and outputs; frame_start is low in such cycles.
REQ-023 At counter terminal count, the counter clears to 0 on the state transition; no wrap beyond SHOW_CYCLES-1 or BLANK_CYCLES-1.

Reset
REQ-024 rst_n low at a clock edge: state <= LOAD, d <= 0, counter <= 0, shadow <= 0, lzb_q <= 0, seg_n <= 7'h7F, digit_n <= 4'hF, frame_start <= 0; applies regardless of clk_enable.
REQ-025 Reset asserted mid-SHOW or mid-BLANK aborts the frame; the first enabled cycle after release is LOAD.

Structure
REQ-026 Package display_pkg SHALL hold the state enum, the 16-entry segment table constant and the default SHOW_CYCLES and BLANK_CYCLES values.
REQ-027 Combinational sub-module hex_to_seg (4-bit nibble in, 7-bit active-low segments out) SHALL implement REQ-021.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=1 unless stated)
REQ-028 display_in = ~16'h1234, lzb = 0 -> digits 0..3 show seg_n 19, 30, 24, 79 in turn; frame_start period 21 cycles.
REQ-029 display_in changes from ~16'h1234 to ~16'hABCD in the cycle after LOAD -> current frame shows 1234; next frame shows 21, 46, 03, 08.
REQ-030 display_in = ~16'h0005, lzb = 1 -> only digit 0 lit (seg_n 12); digit_n = 4'hF in the other three SHOW windows; the 21-cycle period is kept.
REQ-031 clk_enable toggled 1010 throughout -> identical output sequence at half rate; frame_start width is still one clock.
REQ-032 rst_n pulsed low mid-SHOW of digit 2 -> next cycle seg_n = 7F, digit_n = F; the first post-release enabled cycle asserts frame_start.
REQ-033 BLANK_CYCLES = 0 -> no all-off gap between digits; frame period 17 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package display_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_SHOW_CYCLES  = 1024;
    localparam int unsigned DEFAULT_BLANK_CYCLES = 16;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when digit idx and every more-significant nibble are zero; digit 0 never qualifies.
    function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] idx);
        logic result;
        case (idx)
            2'd1:    result = (value[15:4] == 12'h000);
            2'd2:    result = (value[15:8] == 8'h00);
            2'd3:    result = (value[15:12] == 4'h0);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner: snapshots the display word once per
// frame, then walks digits 0..3 with optional blanking gaps and leading-zero suppression.
module seven_seg_scanner
    import display_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES  = DEFAULT_SHOW_CYCLES,
    parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [15:0] display_in,
    input  logic        lzb,
    output logic [6:0]  seg_n,
    output logic [3:0]  digit_n,
    output logic        frame_start
);

    localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 16'h0000 : 16'(BLANK_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  d;
    logic [1:0]  d_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [15:0] shadow;
    logic        lzb_q;
    logic [3:0]  nibble;
    logic [6:0]  seg_dec;
    logic [6:0]  seg_next;
    logic [3:0]  digit_next;
    logic        blank_digit;

    always_comb begin
        case (d)
            2'd0:    nibble = shadow[3:0];
            2'd1:    nibble = shadow[7:4];
            2'd2:    nibble = shadow[11:8];
            default: nibble = shadow[15:12];
        endcase
    end

    hex_to_seg u_dec (
        .nibble (nibble),
        .seg_n  (seg_dec)
    );

    assign blank_digit = lzb_q && lead_zero(shadow, d);

    // Output registers take the values belonging to the current state, so they lag it by one cycle.
    always_comb begin
        state_next = state;
        d_next     = d;
        cnt_next   = cnt;
        seg_next   = '1;
        digit_next = '1;
        case (state)
            ST_LOAD: begin
                state_next = ST_SHOW;
                d_next     = '0;
                cnt_next   = '0;
            end
            ST_SHOW: begin
                if (!blank_digit) begin
                    seg_next   = seg_dec;
                    digit_next = ~(4'b0001 << d);
                end
                if (cnt == SHOW_LAST) begin
                    cnt_next = '0;
                    if (BLANK_CYCLES != 0) begin
                        state_next = ST_BLANK;
                    end else if (d == 2'd3) begin
                        state_next = ST_LOAD;
                    end else begin
                        d_next     = d + 2'd1;
                        state_next = ST_SHOW;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_next = '0;
                    if (d == 2'd3) begin
                        state_next = ST_LOAD;
                    end else begin
                        d_next     = d + 2'd1;
                        state_next = ST_SHOW;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: begin
                state_next = ST_LOAD;
                d_next     = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_LOAD;
            d       <= '0;
            cnt     <= '0;
            shadow  <= '0;
            lzb_q   <= 1'b0;
            seg_n   <= '1;
            digit_n <= '1;
        end else if (clk_enable) begin
            state   <= state_next;
            d       <= d_next;
            cnt     <= cnt_next;
            seg_n   <= seg_next;
            digit_n <= digit_next;
            if (state == ST_LOAD) begin
                shadow <= ~display_in;
                lzb_q  <= lzb;
            end
        end
    end

    // Combinational so the pulse coincides with the enabled LOAD cycle itself.
    assign frame_start = rst_n && clk_enable && (state == ST_LOAD);

endmodule
